sdc_fft_reorder: RTL

Streaming bit-reversal reorder buffer on the output side of the SDC FFT datapath. Accepts one complex sample per cycle in bit-reversed index order (the FFT output stream) and re-emits each N-sample frame in natural index order. Ping-pong storage of two N-entry banks lets frame k+1 be written while frame k is read. Valid/ready handshake on both sides; the upstream `valid` is driven from the FFT `done` flag.

---
 rtl/sdc_fft_pkg.sv | 29 ++
 rtl/sdc_pingpong_ram.sv | 28 ++
 rtl/sdc_fft_reorder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sdc_fft_pkg.sv
// Shared types and helpers for the SDC FFT output reorder path:
// bit-reversal of a frame index, read FSM states and saturation limits.
package sdc_fft_pkg;

  localparam int unsigned MAX_LOG2N = 6;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Reverse the low log2n bits of idx; bits above log2n come back as zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] idx,
                                                  input int unsigned log2n);
    logic [MAX_LOG2N-1:0] rev;
    rev = {<<{idx}};
    return rev >> (MAX_LOG2N - log2n);
  endfunction

  // Two's-complement limits of a w-bit component, as 32-bit patterns to be truncated to w bits.
  function automatic logic [31:0] sat_pos_lim(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_neg_lim(input int unsigned w);
    return ~sat_pos_lim(w);
  endfunction

endpackage

// File: rtl/sdc_pingpong_ram.sv
// Two-bank sample store: bank select is the address MSB, one write port,
// combinational read port so the output register can load in the same cycle.
module sdc_pingpong_ram
  import sdc_fft_pkg::*;
#(
  parameter int width = 12,
  parameter int N     = 16,
  parameter int LOG2N = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [LOG2N:0]       waddr,
  input  logic [2*width-1:0]   wdata,
  input  logic [LOG2N:0]       raddr,
  output logic [2*width-1:0]   rdata
);

  logic [2*width-1:0] mem [2*N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sdc_fft_reorder.sv
// Bit-reversed to natural-order frame reorder with ping-pong banks and valid/ready on both sides.
// Define SDC_REORDER_CONJ_EN to emit the saturated complex conjugate (I_out = -I).
module sdc_fft_reorder
  import sdc_fft_pkg::*;
#(
  parameter int width = 12,
  parameter int N     = 16,
  parameter int LOG2N = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [width-1:0] R,
  input  logic signed [width-1:0] I,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [width-1:0] R_out,
  output logic signed [width-1:0] I_out,
  output logic                    out_last
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  rd_state_e               state_q, state_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [1:0]              full_q, full_d;
  logic [LOG2N-1:0]        wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0]        rd_cnt_q, rd_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic signed [width-1:0] r_out_q, r_out_d;
  logic signed [width-1:0] i_out_q, i_out_d;

  logic                    wr_fire;
  logic                    wr_done;
  logic [LOG2N-1:0]        wr_addr;
  logic                    out_free;
  logic                    load;
  logic                    rd_done;
  logic [2*width-1:0]      rd_data;
  logic signed [width-1:0] rd_r;
  logic signed [width-1:0] rd_i;
  logic signed [width-1:0] i_load;

  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = in_valid && in_ready;
  assign wr_done  = wr_fire && (wr_cnt_q == LAST_IDX);
  assign wr_addr  = LOG2N'(bitrev(MAX_LOG2N'(wr_cnt_q), LOG2N));

  // The output register refills whenever it is empty or being drained this cycle.
  assign out_free = !out_valid_q || out_ready;
  assign load     = out_free && ((state_q == RD_READ) || full_q[rd_bank_q]);
  // A bank is released once its last sample has moved into the output register,
  // which lets the writer re-enter it without a gap under full throughput.
  assign rd_done  = load && (rd_cnt_q == LAST_IDX);

  sdc_pingpong_ram #(
    .width (width),
    .N     (N),
    .LOG2N (LOG2N)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr ({wr_bank_q, wr_addr}),
    .wdata ({R, I}),
    .raddr ({rd_bank_q, rd_cnt_q}),
    .rdata (rd_data)
  );

  assign rd_r = rd_data[2*width-1:width];
  assign rd_i = rd_data[width-1:0];

`ifdef SDC_REORDER_CONJ_EN
  localparam logic signed [width-1:0] SAT_MAX = width'(sat_pos_lim(width));
  localparam logic signed [width-1:0] SAT_MIN = width'(sat_neg_lim(width));

  assign i_load = (rd_i == SAT_MIN) ? SAT_MAX : -rd_i;
`else
  assign i_load = rd_i;
`endif

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_done) begin
        wr_bank_d = ~wr_bank_q;
      end
    end
  end

  // Read FSM: READ means the current rd_bank is being streamed out.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;
    unique case (state_q)
      RD_IDLE: if (load) state_d = RD_READ;
      RD_READ: state_d = RD_READ;
      default: state_d = RD_IDLE;
    endcase
    if (load) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
    if (rd_done) begin
      rd_bank_d = ~rd_bank_q;
      state_d   = full_q[~rd_bank_q] ? RD_READ : RD_IDLE;
    end
  end

  // Write completion and bank release always target different banks, so both apply.
  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_last_d  = out_last_q;
    r_out_d     = r_out_q;
    i_out_d     = i_out_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_last_d  = (rd_cnt_q == LAST_IDX);
      r_out_d     = rd_r;
      i_out_d     = i_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RD_IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      r_out_q     <= '0;
      i_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      r_out_q     <= r_out_d;
      i_out_q     <= i_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign R_out     = r_out_q;
  assign I_out     = i_out_q;

endmodule
